// File: rtl/cnn_pkg.sv
// Shared LeNet pipeline types and constants.
// Holds class count, score width and the argmax FSM encoding.
package cnn_pkg;

  localparam int CNN_N_CLASS = 10;
  localparam int CNN_DATA_W  = 16;
  localparam logic [7:0] CNN_IDX_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dense_argmax_unit_if.sv
// Dense-layer write stream and classification result bundle.
// master drives the stream, slave is the argmax unit.
interface dense_argmax_unit_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              layer_fin;
  logic [7:0]        res;
  logic [DATA_W-1:0] res_score;
  logic [7:0]        res2;
  logic              res_valid;
  logic              busy;
  logic              err;

  modport master (
    output start, wr_en, wr_addr, wr_data, layer_fin,
    input  res, res_score, res2, res_valid, busy, err
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, layer_fin,
    output res, res_score, res2, res_valid, busy, err
  );
endinterface

// File: rtl/argmax_cmp.sv
// Combinational signed compare-select for the argmax scan.
// Equal scores keep the lower index; an empty best always loses.
module argmax_cmp
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W
) (
  input  logic signed [DATA_W-1:0] best_val_i,
  input  logic        [7:0]        best_idx_i,
  input  logic signed [DATA_W-1:0] cand_val_i,
  input  logic        [7:0]        cand_idx_i,
  input  logic                     cand_ok_i,
  output logic signed [DATA_W-1:0] new_val_o,
  output logic        [7:0]        new_idx_o
);
  logic take;

  assign take = cand_ok_i &&
    ((best_idx_i == CNN_IDX_NONE) ||
     (cand_val_i > best_val_i) ||
     ((cand_val_i == best_val_i) &&
      (cand_idx_i < best_idx_i)));

  assign new_val_o = take ? cand_val_i : best_val_i;
  assign new_idx_o = take ? cand_idx_i : best_idx_i;
endmodule

// File: rtl/dense_argmax_unit.sv
// Class-score capture and argmax over the final dense layer.
// Define ARGMAX_TOP2_EN to also track the runner-up class on res2.
module dense_argmax_unit
  import cnn_pkg::*;
#(
  parameter int N_CLASS = CNN_N_CLASS,
  parameter int DATA_W  = CNN_DATA_W
) (
  input logic clk,
  input logic rst_n,
  dense_argmax_unit_if.slave argmax_if
);
  localparam int AW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam logic [7:0] LAST = 8'(N_CLASS - 1);
  localparam logic signed [DATA_W-1:0] VMIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  state_e                   state_q;
  logic signed [DATA_W-1:0] score_q [N_CLASS];
  logic [N_CLASS-1:0]       mask_q;
  logic [7:0]               idx_q;
  logic signed [DATA_W-1:0] best_val_q;
  logic [7:0]               best_idx_q;
  logic [7:0]               res_q;
  logic [DATA_W-1:0]        res_score_q;
  logic                     res_valid_q;
  logic                     err_q;
  logic                     fin_q;

  logic [AW-1:0]            waddr;
  logic [AW-1:0]            sidx;
  logic                     wr_ok;
  logic                     fin_rise;
  logic signed [DATA_W-1:0] cand_val;
  logic                     cand_ok;
  logic signed [DATA_W-1:0] new_val;
  logic [7:0]               new_idx;

  assign waddr    = argmax_if.wr_addr[AW-1:0];
  assign sidx     = idx_q[AW-1:0];
  assign wr_ok    = argmax_if.wr_addr < 32'(N_CLASS);
  assign fin_rise = argmax_if.layer_fin & ~fin_q;
  assign cand_val = score_q[sidx];
  assign cand_ok  = mask_q[sidx];

  argmax_cmp #(.DATA_W(DATA_W)) u_cmp (
    .best_val_i (best_val_q),
    .best_idx_i (best_idx_q),
    .cand_val_i (cand_val),
    .cand_idx_i (idx_q),
    .cand_ok_i  (cand_ok),
    .new_val_o  (new_val),
    .new_idx_o  (new_idx)
  );

`ifdef ARGMAX_TOP2_EN
  logic signed [DATA_W-1:0] sec_val_q;
  logic [7:0]               sec_idx_q;
  logic [7:0]               res2_q;
  logic                     take;
  logic signed [DATA_W-1:0] lose_val;
  logic [7:0]               lose_idx;
  logic                     lose_ok;
  logic signed [DATA_W-1:0] sec_new_val;
  logic [7:0]               sec_new_idx;

  // whichever entry lost the primary compare competes for second place
  assign take     = new_idx != best_idx_q;
  assign lose_val = take ? best_val_q : cand_val;
  assign lose_idx = take ? best_idx_q : idx_q;
  assign lose_ok  = take ? (best_idx_q != CNN_IDX_NONE) : cand_ok;

  argmax_cmp #(.DATA_W(DATA_W)) u_cmp2 (
    .best_val_i (sec_val_q),
    .best_idx_i (sec_idx_q),
    .cand_val_i (lose_val),
    .cand_idx_i (lose_idx),
    .cand_ok_i  (lose_ok),
    .new_val_o  (sec_new_val),
    .new_idx_o  (sec_new_idx)
  );

  assign argmax_if.res2 = res2_q;
`else
  assign argmax_if.res2 = CNN_IDX_NONE;
`endif

  assign argmax_if.res       = res_q;
  assign argmax_if.res_score = res_score_q;
  assign argmax_if.res_valid = res_valid_q;
  assign argmax_if.err       = err_q;
  assign argmax_if.busy      = (state_q == ST_COLLECT) ||
                               (state_q == ST_SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_q     <= '{default: '0};
      mask_q      <= '0;
      idx_q       <= '0;
      best_val_q  <= VMIN;
      best_idx_q  <= CNN_IDX_NONE;
      res_q       <= CNN_IDX_NONE;
      res_score_q <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      fin_q       <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      sec_val_q   <= VMIN;
      sec_idx_q   <= CNN_IDX_NONE;
      res2_q      <= CNN_IDX_NONE;
`endif
    end else begin
      fin_q <= argmax_if.layer_fin;
      if (argmax_if.start) begin
        state_q     <= ST_COLLECT;
        score_q     <= '{default: '0};
        mask_q      <= '0;
        err_q       <= 1'b0;
        res_valid_q <= 1'b0;
        res_q       <= CNN_IDX_NONE;
        res_score_q <= '0;
`ifdef ARGMAX_TOP2_EN
        res2_q      <= CNN_IDX_NONE;
`endif
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_COLLECT: begin
            if (argmax_if.wr_en) begin
              if (wr_ok) begin
                score_q[waddr] <= argmax_if.wr_data;
                mask_q[waddr]  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            if (fin_rise || (&mask_q)) begin
              state_q    <= ST_SCAN;
              idx_q      <= '0;
              best_val_q <= VMIN;
              best_idx_q <= CNN_IDX_NONE;
`ifdef ARGMAX_TOP2_EN
              sec_val_q  <= VMIN;
              sec_idx_q  <= CNN_IDX_NONE;
`endif
            end
          end
          ST_SCAN: begin
            best_val_q <= new_val;
            best_idx_q <= new_idx;
`ifdef ARGMAX_TOP2_EN
            sec_val_q  <= sec_new_val;
            sec_idx_q  <= sec_new_idx;
`endif
            if (!cand_ok) err_q <= 1'b1;
            if (idx_q == LAST) begin
              state_q     <= ST_DONE;
              res_q       <= new_idx;
              res_score_q <= (new_idx == CNN_IDX_NONE) ? '0 : new_val;
              res_valid_q <= 1'b1;
`ifdef ARGMAX_TOP2_EN
              res2_q      <= sec_new_idx;
`endif
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
          ST_DONE: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dense_argmax_unit.sv
// Randomized self-checking bench for dense_argmax_unit.
// Expected results come from a plain array argmax model.
module tb_dense_argmax_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  dense_argmax_unit_if #(.DATA_W(16)) bus ();

  dense_argmax_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .argmax_if (bus)
  );

  always #5 clk = ~clk;

  int          wa[$];
  logic [15:0] wd[$];
  logic [7:0]  m_res;
  logic [7:0]  m_res2;
  logic [15:0] m_score;
  logic        m_err;

  function automatic void model();
    logic signed [15:0] s [10];
    bit w [10];
    int best = -1;
    int sec = -1;
    m_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s[i] = '0;
      w[i] = 1'b0;
    end
    foreach (wa[k]) begin
      if (wa[k] >= 0 && wa[k] < 10) begin
        s[wa[k]] = $signed(wd[k]);
        w[wa[k]] = 1'b1;
      end else m_err = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      if (!w[i]) m_err = 1'b1;
      else if (best < 0 || s[i] > s[best]) best = i;
    end
    for (int i = 0; i < 10; i++)
      if (w[i] && i != best && (sec < 0 || s[i] > s[sec])) sec = i;
    m_res   = (best < 0) ? 8'hFF : 8'(best);
    m_score = (best < 0) ? 16'h0 : s[best];
`ifdef ARGMAX_TOP2_EN
    m_res2  = (sec < 0) ? 8'hFF : 8'(sec);
`else
    m_res2  = 8'hFF;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drive_writes();
    foreach (wa[i]) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = wa[i];
      bus.wr_data = wd[i];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_frame(input int hold);
    pulse_start();
    drive_writes();
    bus.layer_fin = 1'b1;
    repeat (hold) tick();
    bus.layer_fin = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.res_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout res_valid=%b required 1", name, bus.res_valid);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.wr_en = 0; bus.wr_addr = 0;
    bus.wr_data = 0; bus.layer_fin = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks += 6;
    if (bus.res !== 8'hFF) begin errors++;
      $display("FAIL reset_res got %h want ff", bus.res); end
    if (bus.res2 !== 8'hFF) begin errors++;
      $display("FAIL reset_res2 got %h want ff", bus.res2); end
    if (bus.res_score !== 16'h0) begin errors++;
      $display("FAIL reset_score got %h want 0", bus.res_score); end
    if (bus.res_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", bus.res_valid); end
    if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.err !== 1'b0) begin errors++;
      $display("FAIL reset_err got %b want 0", bus.err); end
    // layer_fin while idle must not start anything
    bus.layer_fin = 1'b1;
    repeat (3) tick();
    bus.layer_fin = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++;
      $display("FAIL idle_fin busy=%b valid=%b want 0 0", bus.busy, bus.res_valid); end
  endtask

  task automatic test_basic();
    int lat = 0;
    logic [15:0] sc [10] = '{16'd5, -16'sd3, 16'd7, 16'd2, 16'd7,
                            16'd0, -16'sd8, 16'd1, 16'd6, 16'd4};
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) begin wa.push_back(i); wd.push_back(sc[i]); end
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL basic_busy got %b want 1", bus.busy); end
    drive_writes();
    bus.layer_fin = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.res_valid === 1'b1 && lat == 0) lat = k;
    end
    bus.layer_fin = 1'b0;
    checks += 6;
    if (lat != 11) begin errors++;
      $display("FAIL basic_latency got %0d want 11", lat); end
    if (bus.res !== 8'd2) begin errors++;
      $display("FAIL basic_res got %0d want 2", bus.res); end
    if (bus.res_score !== 16'd7) begin errors++;
      $display("FAIL basic_score got %h want 0007", bus.res_score); end
    if (bus.err !== 1'b0) begin errors++;
      $display("FAIL basic_err got %b want 0", bus.err); end
    if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL basic_done_busy got %b want 0", bus.busy); end
`ifdef ARGMAX_TOP2_EN
    if (bus.res2 !== 8'd4) begin errors++;
      $display("FAIL basic_res2 got %0d want 4", bus.res2); end
`else
    if (bus.res2 !== 8'hFF) begin errors++;
      $display("FAIL basic_res2 got %0d want 255", bus.res2); end
`endif
    // stray traffic in DONE is ignored
    bus.wr_en = 1'b1; bus.wr_addr = 3; bus.wr_data = 16'h7FFF;
    bus.layer_fin = 1'b1;
    repeat (3) tick();
    bus.wr_en = 1'b0; bus.layer_fin = 1'b0;
    tick();
    checks++;
    if (bus.res !== 8'd2 || bus.err !== 1'b0 || bus.res_valid !== 1'b1) begin errors++;
      $display("FAIL done_hold res=%0d err=%b valid=%b want 2 0 1",
               bus.res, bus.err, bus.res_valid); end
  endtask

  task automatic test_most_negative();
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) begin wa.push_back(i); wd.push_back(16'h8000); end
    run_frame(1);
    wait_valid("most_neg");
    checks += 3;
    if (bus.res !== 8'd0) begin errors++;
      $display("FAIL most_neg_res got %0d want 0", bus.res); end
    if (bus.res_score !== 16'h8000) begin errors++;
      $display("FAIL most_neg_score got %h want 8000", bus.res_score); end
    if (bus.err !== 1'b0) begin errors++;
      $display("FAIL most_neg_err got %b want 0", bus.err); end
  endtask

  task automatic test_bad_addr();
    wa.delete(); wd.delete();
    wa.push_back(12); wd.push_back(16'h7FFF);
    for (int i = 0; i < 10; i++) begin wa.push_back(i); wd.push_back(16'($urandom)); end
    model();
    run_frame(2);
    wait_valid("bad_addr");
    checks += 3;
    if (bus.err !== 1'b1) begin errors++;
      $display("FAIL bad_addr_err got %b want 1", bus.err); end
    if (bus.res !== m_res) begin errors++;
      $display("FAIL bad_addr_res got %0d want %0d", bus.res, m_res); end
    if (bus.res_score !== m_score) begin errors++;
      $display("FAIL bad_addr_score got %h want %h", bus.res_score, m_score); end
  endtask

  task automatic test_missing();
    wa.delete(); wd.delete();
    for (int i = 0; i < 9; i++) begin wa.push_back(i); wd.push_back(16'($urandom)); end
    model();
    run_frame(1);
    wait_valid("missing");
    checks += 3;
    if (bus.err !== 1'b1) begin errors++;
      $display("FAIL missing_err got %b want 1", bus.err); end
    if (bus.res !== m_res) begin errors++;
      $display("FAIL missing_res got %0d want %0d", bus.res, m_res); end
    if (bus.res2 !== m_res2) begin errors++;
      $display("FAIL missing_res2 got %0d want %0d", bus.res2, m_res2); end
  endtask

  task automatic test_restart();
    wa.delete(); wd.delete();
    for (int i = 0; i < 4; i++) begin wa.push_back(i); wd.push_back(16'h7FFF); end
    pulse_start();
    drive_writes();
    wa.delete(); wd.delete();
    for (int i = 4; i < 10; i++) begin
      wa.push_back(i); wd.push_back(16'($urandom_range(0, 2000)));
    end
    model();
    run_frame(1);
    wait_valid("restart");
    checks += 3;
    if (bus.res !== m_res) begin errors++;
      $display("FAIL restart_res got %0d want %0d", bus.res, m_res); end
    if (bus.res_score !== m_score) begin errors++;
      $display("FAIL restart_score got %h want %h", bus.res_score, m_score); end
    if (bus.err !== m_err) begin errors++;
      $display("FAIL restart_err got %b want %b", bus.err, m_err); end
  endtask

  task automatic test_async_reset();
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) begin wa.push_back(i); wd.push_back(16'($urandom)); end
    run_frame(1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.res !== 8'hFF || bus.res_score !== 16'h0 || bus.res2 !== 8'hFF) begin errors++;
      $display("FAIL arst_result res=%h score=%h res2=%h want ff 0 ff",
               bus.res, bus.res_score, bus.res2); end
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin errors++;
      $display("FAIL arst_flags valid=%b busy=%b err=%b want 0 0 0",
               bus.res_valid, bus.busy, bus.err); end
    tick();
    rst_n = 1'b1;
    tick();
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) begin wa.push_back(i); wd.push_back(16'($urandom)); end
    model();
    run_frame(1);
    wait_valid("arst_next");
    checks++;
    if (bus.res !== m_res || bus.res_score !== m_score || bus.err !== m_err) begin errors++;
      $display("FAIL arst_next res=%0d score=%h err=%b want %0d %h %b",
               bus.res, bus.res_score, bus.err, m_res, m_score, m_err); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int m = $urandom_range(0, 14);
      bit narrow = $urandom_range(0, 1) == 1;
      wa.delete(); wd.delete();
      // index 9 appears only as the final write so the frame ends on layer_fin
      for (int j = 0; j <= m; j++) begin
        int a;
        if (j == m) begin
          if ($urandom_range(0, 3) == 0) break;
          a = 9;
        end else if ($urandom_range(0, 9) < 2) a = $urandom_range(10, 300);
        else a = $urandom_range(0, 8);
        wa.push_back(a);
        wd.push_back(narrow ? 16'($signed($urandom_range(0, 4)) - 2) : 16'($urandom));
      end
      model();
      run_frame($urandom_range(1, 3));
      wait_valid("rand_valid");
      checks += 4;
      if (bus.res !== m_res) begin errors++;
        $display("FAIL rand_res it=%0d got %0d want %0d", it, bus.res, m_res); end
      if (bus.res_score !== m_score) begin errors++;
        $display("FAIL rand_score it=%0d got %h want %h", it, bus.res_score, m_score); end
      if (bus.err !== m_err) begin errors++;
        $display("FAIL rand_err it=%0d got %b want %b", it, bus.err, m_err); end
      if (bus.res2 !== m_res2) begin errors++;
        $display("FAIL rand_res2 it=%0d got %0d want %0d", it, bus.res2, m_res2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_most_negative();
    test_bad_addr();
    test_missing();
    test_restart();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
